z16_sequencer: RTL and testbench
================================

Name: z16_sequencer

Overview:
Multi-cycle control FSM for the Z16 CPU core. It owns the program counter and sequences each instruction through fetch, decode, execute, memory and writeback. It drives the instruction/data memory request handshakes, the instruction-register load, the register-file write strobe and PC update. It consumes the combinational decoder outputs (opcode, rd_wen, mem_wen) and the ALU branch-condition flag.

Parameters:
PC_RESET, 16'h0000, PC value loaded on reset
PC_STEP, 16'h0002, PC increment for sequential flow
TIMEOUT, 16, max wait cycles per memory handshake before fault; 0 disables timeout

Ports:
i_clk  in  1  clock, all state on rising edge
i_rst  in  1  synchronous active-high reset
i_imem_ack  in  1  instruction memory read done; data valid this cycle
o_imem_req  out  1  instruction read request
o_ir_we  out  1  load instruction register (1-cycle pulse)
i_opcode  in  4  decoder opcode
i_rd_wen  in  1  decoder register-write enable
i_mem_wen  in  1  decoder memory-write enable
i_cond  in  1  ALU branch condition (valid in EXEC/WB)
i_target  in  16  jump/branch target address from datapath
i_dmem_ack  in  1  data memory access done
o_dmem_req  out  1  data memory request
o_dmem_we  out  1  data memory write (store)
o_rf_wen  out  1  register-file write strobe
o_pc  out  16  current PC
o_state  out  3  FSM state: 0 FETCH,1 DECODE,2 EXEC,3 MEM,4 WB,7 FAULT
o_fault  out  1  sticky handshake-timeout fault

Behaviour:
- Reset (i_rst=1 at edge): state FETCH, o_pc=PC_RESET, wait counter 0, o_fault=0, all strobes 0. Reset mid-transaction abandons it; no writeback/PC update occurs.
- All strobes combinational from registered state/latched opcode only; no input-to-output path except ack gating o_ir_we.
- FETCH: o_imem_req=1. On i_imem_ack: o_ir_we=1 same cycle, -> DECODE. Zero-wait ack (first FETCH cycle) accepted.
- DECODE: latch op_q=i_opcode, rdw_q=i_rd_wen, memw_q=i_mem_wen. Always -> EXEC next cycle.
- EXEC: one cycle. op_q==4'hA or op_q==4'hB -> MEM; else -> WB.
- MEM: o_dmem_req=1, o_dmem_we=memw_q (1 for 4'hB). On i_dmem_ack -> WB.
- WB: o_rf_wen=rdw_q (0 for store, branches E/F). PC update: take = (op_q==C or D) or ((op_q==E or F) and i_cond); o_pc <= take ? i_target : o_pc+PC_STEP (16-bit wrap, 16'hFFFE+2=16'h0000). -> FETCH.
- Latency (zero-wait acks): non-memory instr 4 cycles, load/store 5 cycles; each ack wait cycle adds 1.
- Acks outside their request state ignored; simultaneous imem/dmem ack: only the one matching current state acts.
- Timeout: counter clears on state entry; increments each FETCH/MEM cycle without ack. If TIMEOUT!=0 and counter reaches TIMEOUT-1 without ack -> FAULT. FAULT: o_fault=1, all requests/strobes 0, PC frozen, exit only by reset.
- o_pc constant except at WB edge and reset.

Optional Feature:
Z16_SEQ_PERF_EN: adds output o_retired [31:0], counter incremented at each WB cycle (wraps at 2^32), cleared by reset, frozen in FAULT. Without the macro, port and counter are absent; all other behaviour identical.

Test Plan:
- Reset, op=4'h0, zero-wait imem ack -> states 0,1,2,4,0; o_rf_wen=1 in WB only; o_pc 0x0000->0x0002 after 4 cycles.
- Store op=4'hB, dmem ack after 3 wait cycles -> o_dmem_req=1/o_dmem_we=1 for 4 cycles, o_rf_wen=0, total 8 cycles, PC+2.
- Branch op=4'hE, i_cond=1, i_target=0x0040 -> o_pc=0x0040; repeat with i_cond=0 -> PC+2; op=4'hC ignores i_cond, jumps, o_rf_wen=1.
- TIMEOUT=16, imem ack never asserted -> o_state=7, o_fault=1 after 16 FETCH cycles, o_imem_req=0; i_rst -> FETCH, PC=PC_RESET, o_fault=0.
- i_rst asserted during MEM with load pending -> next cycle FETCH, no o_rf_wen, PC=PC_RESET; stray i_dmem_ack in FETCH ignored.
- PC wrap: PC at 0xFFFE, non-branch op -> o_pc=0x0000; with Z16_SEQ_PERF_EN, o_retired increments by 1 per instruction.

Source files
------------

// File: rtl/z16_sequencer.sv
// Z16 multi-cycle control FSM: owns the PC and steps each instruction through fetch/decode/exec/mem/wb.
// Optional Z16_SEQ_PERF_EN macro adds the o_retired instruction counter.
module z16_sequencer #(
  parameter logic [15:0] PC_RESET = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'h0002,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_imem_ack,
  output logic        o_imem_req,
  output logic        o_ir_we,
  input  logic [3:0]  i_opcode,
  input  logic        i_rd_wen,
  input  logic        i_mem_wen,
  input  logic        i_cond,
  input  logic [15:0] i_target,
  input  logic        i_dmem_ack,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic        o_rf_wen,
  output logic [15:0] o_pc,
  output logic [2:0]  o_state,
  output logic        o_fault
`ifdef Z16_SEQ_PERF_EN
  ,
  output logic [31:0] o_retired
`endif
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_FAULT  = 3'd7
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic [15:0] pc;
  logic [15:0] wait_cnt;
  logic [3:0]  op_q;
  logic        rdw_q;
  logic        memw_q;
  logic        fault_q;
  logic        is_mem;
  logic        take;
  logic        timeout_hit;

  assign is_mem      = (op_q == 4'hA) || (op_q == 4'hB);
  assign take        = (op_q == 4'hC) || (op_q == 4'hD) ||
                       (((op_q == 4'hE) || (op_q == 4'hF)) && i_cond);
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == TO_LAST);

  // Handshake: a request stays high for the whole FETCH/MEM state; the transfer
  // completes in the cycle its ack is seen with the request high. Acks seen at
  // any other time, or for the other memory, are ignored.
  assign o_imem_req = (state == ST_FETCH);
  assign o_ir_we    = (state == ST_FETCH) && i_imem_ack;
  assign o_dmem_req = (state == ST_MEM);
  assign o_dmem_we  = (state == ST_MEM) && memw_q;
  assign o_rf_wen   = (state == ST_WB) && rdw_q;
  assign o_pc       = pc;
  assign o_state    = state;
  assign o_fault    = fault_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= ST_FETCH;
      pc       <= PC_RESET;
      wait_cnt <= '0;
      fault_q  <= 1'b0;
      op_q     <= '0;
      rdw_q    <= 1'b0;
      memw_q   <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (i_imem_ack) begin
            state    <= ST_DECODE;
            wait_cnt <= '0;
          end else if (timeout_hit) begin
            state    <= ST_FAULT;
            fault_q  <= 1'b1;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        ST_DECODE: begin
          op_q   <= i_opcode;
          rdw_q  <= i_rd_wen;
          memw_q <= i_mem_wen;
          state  <= ST_EXEC;
        end
        ST_EXEC: begin
          state <= is_mem ? ST_MEM : ST_WB;
        end
        ST_MEM: begin
          if (i_dmem_ack) begin
            state    <= ST_WB;
            wait_cnt <= '0;
          end else if (timeout_hit) begin
            state    <= ST_FAULT;
            fault_q  <= 1'b1;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        ST_WB: begin
          pc    <= take ? i_target : pc + PC_STEP;
          state <= ST_FETCH;
        end
        ST_FAULT: begin
          state <= ST_FAULT;
        end
        default: begin
          state   <= ST_FAULT;
          fault_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef Z16_SEQ_PERF_EN
  logic [31:0] retired_q;

  // Counts WB cycles only, so it naturally freezes in FAULT.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      retired_q <= '0;
    end else if (state == ST_WB) begin
      retired_q <= retired_q + 32'd1;
    end
  end

  assign o_retired = retired_q;
`endif

endmodule

// File: tb/tb_z16_sequencer.sv
// Self-checking bench for z16_sequencer: directed vector table, hand-written corner
// sequences, and randomized instructions checked against a per-instruction model.
module tb_z16_sequencer;

  logic        clk;
  logic        i_rst;
  logic        i_imem_ack;
  logic        o_imem_req;
  logic        o_ir_we;
  logic [3:0]  i_opcode;
  logic        i_rd_wen;
  logic        i_mem_wen;
  logic        i_cond;
  logic [15:0] i_target;
  logic        i_dmem_ack;
  logic        o_dmem_req;
  logic        o_dmem_we;
  logic        o_rf_wen;
  logic [15:0] o_pc;
  logic [2:0]  o_state;
  logic        o_fault;
`ifdef Z16_SEQ_PERF_EN
  logic [31:0] o_retired;
`endif

  z16_sequencer dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_imem_ack (i_imem_ack),
    .o_imem_req (o_imem_req),
    .o_ir_we    (o_ir_we),
    .i_opcode   (i_opcode),
    .i_rd_wen   (i_rd_wen),
    .i_mem_wen  (i_mem_wen),
    .i_cond     (i_cond),
    .i_target   (i_target),
    .i_dmem_ack (i_dmem_ack),
    .o_dmem_req (o_dmem_req),
    .o_dmem_we  (o_dmem_we),
    .o_rf_wen   (o_rf_wen),
    .o_pc       (o_pc),
    .o_state    (o_state),
    .o_fault    (o_fault)
`ifdef Z16_SEQ_PERF_EN
    ,
    .o_retired  (o_retired)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks;
  int          n_pass;
  logic [15:0] model_pc;
  logic [31:0] exp_retired;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Leaves the bench at posedge+1 with the DUT in its first FETCH cycle.
  task automatic do_reset();
    i_rst      = 1'b1;
    i_imem_ack = 1'b0;
    i_dmem_ack = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 i_rst = 1'b0;
    model_pc    = 16'h0000;
    exp_retired = 32'd0;
  endtask

  function automatic logic dec_rd_wen(input logic [3:0] op);
    return !(op == 4'hB || op == 4'hE || op == 4'hF);
  endfunction

  // ---------------- driver ----------------
  // Plays instruction/data memory for one instruction, starting in FETCH at
  // posedge+1 and returning at posedge+1 of the next FETCH.
  task automatic run_instr(input logic [3:0] op, input logic cond, input logic [15:0] tgt,
                           input int iw, input int dw, input bit stray,
                           output int cyc, output int n_rfw, output int n_dwe,
                           output int n_dreq, output int n_irwe);
    int iw_left;
    int dw_left;
    bit seen_low;
    iw_left = iw;
    dw_left = dw;
    seen_low = 1'b0;
    cyc = 0; n_rfw = 0; n_dwe = 0; n_dreq = 0; n_irwe = 0;
    i_opcode  = op;
    i_rd_wen  = dec_rd_wen(op);
    i_mem_wen = (op == 4'hB);
    i_cond    = cond;
    i_target  = tgt;
    while (cyc < 100) begin
      if (seen_low && o_imem_req) break;
      if (o_imem_req) begin
        i_imem_ack = (iw_left == 0);
        if (iw_left > 0) iw_left--;
      end else begin
        i_imem_ack = stray ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (o_dmem_req) begin
        i_dmem_ack = (dw_left == 0);
        if (dw_left > 0) dw_left--;
      end else begin
        i_dmem_ack = stray ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      @(negedge clk);
      if (o_rf_wen)   n_rfw++;
      if (o_dmem_we)  n_dwe++;
      if (o_dmem_req) n_dreq++;
      if (o_ir_we)    n_irwe++;
      if (!o_imem_req) seen_low = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (cyc >= 100) check("instr_timeout_bound", 32'(cyc), 32'd0);
    i_imem_ack = 1'b0;
    i_dmem_ack = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic        cond;
    logic [15:0] tgt;
    int          iw;
    int          dw;
    int          exp_cyc;
    logic [15:0] exp_pc;
    int          exp_rfw;
    int          exp_dwe;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int cyc, n_rfw, n_dwe, n_dreq, n_irwe;
    int exp_st[5];
    int exp_rf[5];
    int exp_pcs[5];
    int bad;
    logic [15:0] pc_before;

    n_checks = 0;
    n_pass   = 0;
    i_rst = 1'b1; i_imem_ack = 1'b0; i_dmem_ack = 1'b0;
    i_opcode = 4'h0; i_rd_wen = 1'b0; i_mem_wen = 1'b0; i_cond = 1'b0; i_target = 16'h0;

    vecs[0] = '{4'h0, 1'b0, 16'h1234, 0,  0,  4,  16'h0002, 1, 0};
    vecs[1] = '{4'hB, 1'b0, 16'h0000, 0,  3,  8,  16'h0004, 0, 4};
    vecs[2] = '{4'hE, 1'b1, 16'h0040, 0,  0,  4,  16'h0040, 0, 0};
    vecs[3] = '{4'hE, 1'b0, 16'h0080, 0,  0,  4,  16'h0042, 0, 0};
    vecs[4] = '{4'hC, 1'b0, 16'h0100, 0,  0,  4,  16'h0100, 1, 0};
    vecs[5] = '{4'hA, 1'b1, 16'h0200, 2,  1,  8,  16'h0102, 1, 0};
    vecs[6] = '{4'hF, 1'b1, 16'hFFFE, 15, 0,  19, 16'hFFFE, 0, 0};
    vecs[7] = '{4'h3, 1'b1, 16'h0500, 0,  0,  4,  16'h0000, 1, 0};
    vecs[8] = '{4'hD, 1'b0, 16'h0010, 1,  0,  5,  16'h0010, 1, 0};
    vecs[9] = '{4'hB, 1'b0, 16'h0000, 0,  15, 20, 16'h0012, 0, 16};

    // ---- reset state ----
    do_reset();
    @(negedge clk);
    check("rst_state", 32'(o_state), 32'd0);
    check("rst_pc", 32'(o_pc), 32'h0000);
    check("rst_fault", 32'(o_fault), 32'd0);
    check("rst_imem_req", 32'(o_imem_req), 32'd1);
    check("rst_strobes", {28'd0, o_ir_we, o_dmem_req, o_dmem_we, o_rf_wen}, 32'd0);
`ifdef Z16_SEQ_PERF_EN
    check("rst_retired", o_retired, 32'd0);
`endif

    // ---- state trace of a zero-wait ALU op ----
    do_reset();
    exp_st  = '{0, 1, 2, 4, 0};
    exp_rf  = '{0, 0, 0, 1, 0};
    exp_pcs = '{0, 0, 0, 0, 2};
    i_opcode = 4'h0; i_rd_wen = 1'b1; i_mem_wen = 1'b0;
    i_imem_ack = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("trace_state[%0d]", k), 32'(o_state), 32'(exp_st[k]));
      check($sformatf("trace_rf_wen[%0d]", k), 32'(o_rf_wen), 32'(exp_rf[k]));
      check($sformatf("trace_pc[%0d]", k), 32'(o_pc), 32'(exp_pcs[k]));
      @(posedge clk);
      #1 i_imem_ack = 1'b0;
    end

    // ---- imem timeout -> FAULT, then reset recovers ----
    do_reset();
    run_instr(4'h0, 1'b0, 16'h0, 0, 0, 1'b0, cyc, n_rfw, n_dwe, n_dreq, n_irwe);
    exp_retired = 32'd1;
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (o_state != 3'd0) bad++;
      @(posedge clk);
      #1;
    end
    check("to_fetch_hold", 32'(bad), 32'd0);
    @(negedge clk);
    check("to_state", 32'(o_state), 32'd7);
    check("to_fault", 32'(o_fault), 32'd1);
    check("to_imem_req", 32'(o_imem_req), 32'd0);
    @(posedge clk);
    #1 i_imem_ack = 1'b1;
    i_dmem_ack = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("fault_sticky", 32'(o_state), 32'd7);
    check("fault_pc_frozen", 32'(o_pc), 32'h0002);
    check("fault_strobes", {28'd0, o_ir_we, o_dmem_req, o_dmem_we, o_rf_wen}, 32'd0);
`ifdef Z16_SEQ_PERF_EN
    check("fault_retired_frozen", o_retired, exp_retired);
`endif
    do_reset();
    @(negedge clk);
    check("fault_rst_state", 32'(o_state), 32'd0);
    check("fault_rst_pc", 32'(o_pc), 32'h0000);
    check("fault_rst_fault", 32'(o_fault), 32'd0);

    // ---- reset during MEM abandons a load; stray/simultaneous acks ----
    @(posedge clk);
    #1;
    run_instr(4'h0, 1'b0, 16'h0, 0, 0, 1'b0, cyc, n_rfw, n_dwe, n_dreq, n_irwe);
    i_opcode = 4'hA; i_rd_wen = 1'b1; i_mem_wen = 1'b0; i_target = 16'h0300;
    i_imem_ack = 1'b1;
    @(posedge clk);
    #1 i_imem_ack = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("mid_mem_state", 32'(o_state), 32'd3);
    check("mid_mem_dreq", 32'(o_dmem_req), 32'd1);
    i_rst = 1'b1;
    @(posedge clk);
    #1 i_rst = 1'b0;
    i_dmem_ack = 1'b1;
    @(negedge clk);
    check("mem_rst_state", 32'(o_state), 32'd0);
    check("mem_rst_pc", 32'(o_pc), 32'h0000);
    check("mem_rst_rf_wen", 32'(o_rf_wen), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("stray_dack_state", 32'(o_state), 32'd0);
    check("stray_dack_dreq", 32'(o_dmem_req), 32'd0);
    i_imem_ack = 1'b1;
    #1;
    check("dual_ack_ir_we", 32'(o_ir_we), 32'd1);
    @(posedge clk);
    #1 i_imem_ack = 1'b0;
    i_dmem_ack = 1'b0;
    @(negedge clk);
    check("dual_ack_state", 32'(o_state), 32'd1);

    // ---- directed vector table ----
    do_reset();
    for (int v = 0; v < 10; v++) begin
      run_instr(vecs[v].op, vecs[v].cond, vecs[v].tgt, vecs[v].iw, vecs[v].dw, 1'b0,
                cyc, n_rfw, n_dwe, n_dreq, n_irwe);
      exp_retired++;
      check($sformatf("vec%0d_cycles", v), 32'(cyc), 32'(vecs[v].exp_cyc));
      check($sformatf("vec%0d_pc", v), 32'(o_pc), 32'(vecs[v].exp_pc));
      check($sformatf("vec%0d_rf_wen", v), 32'(n_rfw), 32'(vecs[v].exp_rfw));
      check($sformatf("vec%0d_dmem_we", v), 32'(n_dwe), 32'(vecs[v].exp_dwe));
`ifdef Z16_SEQ_PERF_EN
      check($sformatf("vec%0d_retired", v), o_retired, exp_retired);
`endif
    end

    // ---- randomized instructions vs per-instruction model ----
    do_reset();
    for (int n = 0; n < 300; n++) begin
      logic [3:0]  op;
      logic        cond;
      logic [15:0] tgt;
      int          iw, dw;
      bit          is_mem, take;
      int          exp_cyc;
      logic [15:0] exp_pc;
      op   = 4'($urandom_range(0, 15));
      cond = 1'($urandom_range(0, 1));
      tgt  = 16'($urandom_range(0, 65535)) & 16'hFFFE;
      iw   = ($urandom_range(0, 15) == 0) ? 15 : int'($urandom_range(0, 3));
      dw   = ($urandom_range(0, 15) == 0) ? 15 : int'($urandom_range(0, 3));
      is_mem  = (op == 4'hA) || (op == 4'hB);
      take    = (op == 4'hC) || (op == 4'hD) || (((op == 4'hE) || (op == 4'hF)) && cond);
      exp_cyc = 4 + iw + (is_mem ? 1 + dw : 0);
      exp_pc  = take ? tgt : model_pc + 16'd2;
      exp_q.push_back(exp_pc);
      run_instr(op, cond, tgt, iw, dw, 1'b1, cyc, n_rfw, n_dwe, n_dreq, n_irwe);
      exp_retired++;
      model_pc = exp_q.pop_front();
      check("rnd_cycles", 32'(cyc), 32'(exp_cyc));
      check("rnd_pc", 32'(o_pc), 32'(model_pc));
      check("rnd_rf_wen", 32'(n_rfw), dec_rd_wen(op) ? 32'd1 : 32'd0);
      check("rnd_dmem_req", 32'(n_dreq), is_mem ? 32'(1 + dw) : 32'd0);
      check("rnd_dmem_we", 32'(n_dwe), (op == 4'hB) ? 32'(1 + dw) : 32'd0);
      check("rnd_ir_we", 32'(n_irwe), 32'd1);
`ifdef Z16_SEQ_PERF_EN
      check("rnd_retired", o_retired, exp_retired);
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
